// File: rtl/arb_mux_4_1.sv
// Four-requester round-robin arbiter feeding one shared WIDTH-bit output register.
// Optional burst lock (port 'lock') is enabled by defining ARB_MUX_BURST_LOCK_EN.
module arb_mux_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   input  logic               out_ready
`ifdef ARB_MUX_BURST_LOCK_EN
   ,
   input  logic [3:0]         lock
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   out_state_t       out_state;
   logic [1:0]       last_grant;
   logic [1:0]       grant;
   logic             found;
   logic             load;
   logic [WIDTH-1:0] req_data [4];
`ifdef ARB_MUX_BURST_LOCK_EN
   logic             lock_active;
`endif

   assign out_valid = (out_state == FULL);
   assign load      = !out_valid || out_ready;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Search starts one past the last winner, so the last winner comes last.
   always_comb begin
      logic [1:0] cand;
      grant = last_grant;
      found = 1'b0;
      cand  = last_grant;
      for (int k = 1; k <= 4; k++) begin
         cand = last_grant + 2'(k);
         if (!found && in_valid[cand]) begin
            grant = cand;
            found = 1'b1;
         end
      end
`ifdef ARB_MUX_BURST_LOCK_EN
      if (lock_active && in_valid[last_grant]) begin
         grant = last_grant;
         found = 1'b1;
      end
`endif
   end

   always_comb begin
      in_ready = '0;
      if (!rst && load && found) begin
         in_ready[grant] = 1'b1;
      end
   end

   // A load cycle either captures the winner or empties the register when nobody asks.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_state  <= EMPTY;
         out_data   <= '0;
         out_sel    <= 2'd0;
         last_grant <= 2'd3;
`ifdef ARB_MUX_BURST_LOCK_EN
         lock_active <= 1'b0;
`endif
      end else if (load) begin
         if (found) begin
            out_state  <= FULL;
            out_data   <= req_data[grant];
            out_sel    <= grant;
            last_grant <= grant;
`ifdef ARB_MUX_BURST_LOCK_EN
            lock_active <= lock[grant];
`endif
         end else begin
            out_state <= EMPTY;
`ifdef ARB_MUX_BURST_LOCK_EN
            lock_active <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Directed self-checking bench for arb_mux_4_1: reset, rotation, single requester,
// stall, two-requester alternation, mid-transfer reset, withdrawal and optional lock.
module tb_arb_mux_4_1;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [15:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready;
`ifdef ARB_MUX_BURST_LOCK_EN
   logic [3:0]  lock;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   arb_mux_4_1 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
`ifdef ARB_MUX_BURST_LOCK_EN
      ,
      .lock      (lock)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [15:0] d,
                                input logic ordy);
      rst       = r;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 4'hf, 16'hdcba, 1'b1);
      tick();
      tick();
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0000", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 4'h0) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", out_data); end
      total++; if (out_sel !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_sel got=%0d want=0", out_sel); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_data [5];
      logic [1:0] exp_sel  [5];
      exp_data = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
      exp_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      applyStimulus(1'b0, 4'hf, 16'hdcba, 1'b1);
      #1;
      total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL rr_first_ready got=%b want=0001", in_ready); end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rr_valid[%0d] got=%b want=1", i, out_valid); end
         total++; if (out_data !== exp_data[i]) begin bad++; $display("[TB] FAIL rr_data[%0d] got=%h want=%h", i, out_data, exp_data[i]); end
         total++; if (out_sel !== exp_sel[i]) begin bad++; $display("[TB] FAIL rr_sel[%0d] got=%0d want=%0d", i, out_sel, exp_sel[i]); end
      end
   endtask

   task automatic test_single();
      applyStimulus(1'b0, 4'b0100, 16'h0500, 1'b1);
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL single_ready got=%b want=0100", in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid[%0d] got=%b want=1", i, out_valid); end
         total++; if (out_data !== 4'h5) begin bad++; $display("[TB] FAIL single_data[%0d] got=%h want=5", i, out_data); end
         total++; if (out_sel !== 2'd2) begin bad++; $display("[TB] FAIL single_sel[%0d] got=%0d want=2", i, out_sel); end
         total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL single_ready[%0d] got=%b want=0100", i, in_ready); end
      end
   endtask

   task automatic test_hold();
      applyStimulus(1'b0, 4'hf, 16'hdcba, 1'b1);
      tick();
      total++; if (out_data !== 4'hd) begin bad++; $display("[TB] FAIL hold_pre_data got=%h want=d", out_data); end
      tick();
      total++; if (out_data !== 4'ha) begin bad++; $display("[TB] FAIL hold_load_data got=%h want=a", out_data); end
      out_ready = 1'b0;
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL hold_ready got=%b want=0000", in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_data !== 4'ha) begin bad++; $display("[TB] FAIL hold_data[%0d] got=%h want=a", i, out_data); end
         total++; if (out_sel !== 2'd0) begin bad++; $display("[TB] FAIL hold_sel[%0d] got=%0d want=0", i, out_sel); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid[%0d] got=%b want=1", i, out_valid); end
         total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL hold_ready[%0d] got=%b want=0000", i, in_ready); end
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 4'b0010) begin bad++; $display("[TB] FAIL hold_release_ready got=%b want=0010", in_ready); end
      tick();
      total++; if (out_data !== 4'hb) begin bad++; $display("[TB] FAIL hold_release_data got=%h want=b", out_data); end
      total++; if (out_sel !== 2'd1) begin bad++; $display("[TB] FAIL hold_release_sel got=%0d want=1", out_sel); end
   endtask

   task automatic test_two_requesters();
      logic [1:0] exp_sel [4];
      exp_sel = '{2'd0, 2'd1, 2'd0, 2'd1};
      applyStimulus(1'b0, 4'b0011, 16'hdcba, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (out_sel !== exp_sel[i]) begin bad++; $display("[TB] FAIL two_sel[%0d] got=%0d want=%0d", i, out_sel, exp_sel[i]); end
         total++; if (out_data !== (exp_sel[i] == 2'd0 ? 4'ha : 4'hb)) begin bad++; $display("[TB] FAIL two_data[%0d] got=%h", i, out_data); end
      end
      in_valid = 4'b0000;
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL idle_ready got=%b want=0000", in_ready); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 4'hb) begin bad++; $display("[TB] FAIL drain_data_hold got=%h want=b", out_data); end
      total++; if (out_sel !== 2'd1) begin bad++; $display("[TB] FAIL drain_sel_hold got=%0d want=1", out_sel); end
   endtask

   task automatic test_mid_reset();
      applyStimulus(1'b0, 4'b0011, 16'hdcba, 1'b0);
      #1;
      total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL empty_load_ready got=%b want=0001", in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 4'ha) begin bad++; $display("[TB] FAIL empty_load got=%b/%h want=1/a", out_valid, out_data); end
      applyStimulus(1'b1, 4'hf, 16'hdcba, 1'b1);
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_ready got=%b want=0000", in_ready); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 4'h0) begin bad++; $display("[TB] FAIL midrst_data got=%h want=0", out_data); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL midrst_first_ready got=%b want=0001", in_ready); end
      tick();
      total++; if (out_sel !== 2'd0 || out_data !== 4'ha) begin bad++; $display("[TB] FAIL midrst_first got=%0d/%h want=0/a", out_sel, out_data); end
   endtask

   task automatic test_withdraw();
      applyStimulus(1'b0, 4'b0110, 16'hdcba, 1'b0);
      tick();
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL withdraw_ready got=%b want=0100", in_ready); end
      tick();
      total++; if (out_sel !== 2'd2 || out_data !== 4'hc) begin bad++; $display("[TB] FAIL withdraw_out got=%0d/%h want=2/c", out_sel, out_data); end
      in_valid = 4'b0010;
      #1;
      total++; if (in_ready !== 4'b0010) begin bad++; $display("[TB] FAIL withdraw_late_ready got=%b want=0010", in_ready); end
      tick();
      total++; if (out_sel !== 2'd1 || out_data !== 4'hb) begin bad++; $display("[TB] FAIL withdraw_late_out got=%0d/%h want=1/b", out_sel, out_data); end
   endtask

`ifdef ARB_MUX_BURST_LOCK_EN
   task automatic test_lock();
      logic [1:0] exp_sel [4];
      logic [3:0] lock_seq [4];
      logic [3:0] valid_seq [4];
      exp_sel   = '{2'd1, 2'd1, 2'd1, 2'd0};
      lock_seq  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
      valid_seq = '{4'b0010, 4'b0011, 4'b0011, 4'b0011};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, valid_seq[i], 16'hdcba, 1'b1);
         lock = lock_seq[i];
         tick();
         total++; if (out_sel !== exp_sel[i]) begin bad++; $display("[TB] FAIL lock_sel[%0d] got=%0d want=%0d", i, out_sel, exp_sel[i]); end
      end
      lock = 4'b0000;
   endtask
`endif

   initial begin
`ifdef ARB_MUX_BURST_LOCK_EN
      lock = 4'b0000;
`endif
      applyStimulus(1'b1, 4'h0, 16'h0000, 1'b0);
      test_reset();
      test_round_robin();
      test_single();
      test_hold();
      test_two_requesters();
      test_mid_reset();
      test_withdraw();
`ifdef ARB_MUX_BURST_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
